// File: rtl/data_memory_unit.sv
// Word-addressed data memory stage: one load or store per request with a
// programmable access latency, busy/ready handshake and misaligned-request rejection.
module data_memory_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] ALU_result,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_misalign;
  logic [31:0]   r_read_data;
  logic [AW-1:0] r_index;
  logic [31:0]   r_wdata;
  logic          r_is_store;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_aligned;
  logic          w_accept;
  logic          w_enter_done;
  logic          w_load_now;
  logic [AW-1:0] w_index;
  logic [AW-1:0] w_rd_index;
  logic          w_unused_addr;

  assign w_req     = mem_read | mem_write;
  assign w_aligned = (ALU_result[1:0] == 2'b00);
  assign w_index   = ALU_result[AW+1:2];
  // Upper address bits are dropped on purpose: addresses wrap modulo the memory size.
  assign w_unused_addr = ^ALU_result[31:AW+2];

  // The misalign pulse cycle is not a sampling cycle, so a held bad request
  // re-pulses every other cycle.
  assign w_accept = (r_state == IDLE) && !r_misalign && w_req && w_aligned;

  // With zero latency the load happens straight out of IDLE, before the
  // request has been latched, so index and op come from the live inputs.
  assign w_enter_done = (w_accept && (LATENCY == 0)) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0));
  assign w_rd_index   = (r_state == IDLE) ? w_index : r_index;
  assign w_load_now   = w_enter_done &&
                        ((r_state == IDLE) ? !mem_write : !r_is_store);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_misalign  <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_misalign && w_req) begin
            if (w_aligned) begin
              r_state <= (LATENCY == 0) ? DONE : WAIT;
              r_cnt   <= (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
            end else begin
              r_misalign <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_load_now) r_read_data <= r_mem[w_rd_index];
    end
  end

  // NOTE: request latches and the memory array carry no reset; their contents
  // are only meaningful after an accept / a store, and clearing RAM is not wanted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_index    <= w_index;
      r_wdata    <= write_data;
      r_is_store <= mem_write;
    end
  end

  // Commit on the edge leaving DONE so a reset sampled during DONE still cancels the store.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == DONE) && r_is_store) r_mem[r_index] <= r_wdata;
  end

  assign read_data    = r_read_data;
  assign mem_ready    = (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed cases plus randomized
// traffic against a per-transaction reference model, on LATENCY=2 and LATENCY=0 builds.
module tb_data_memory_unit;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mr, mw, rdy, bsy, mis;
  logic [31:0] addr, wdata, rd;
  logic        mr0, mw0, rdy0, bsy0, mis0;
  logic [31:0] addr0, wdata0, rd0;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd;

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .mem_read(mr), .mem_write(mw),
    .ALU_result(addr), .write_data(wdata), .read_data(rd),
    .mem_ready(rdy), .busy(bsy), .misalign_err(mis)
  );

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(mr0), .mem_write(mw0),
    .ALU_result(addr0), .write_data(wdata0), .read_data(rd0),
    .mem_ready(rdy0), .busy(bsy0), .misalign_err(mis0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // NOTE: inputs change 1 time unit after the rising edge and outputs are
  // sampled there too, so nothing races the edge the DUT samples on.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(bsy), 32'd0);
    check({tag, ".rdy"},  32'(rdy), 32'd0);
    check({tag, ".err"},  32'(mis), 32'd0);
    check({tag, ".rd"},   rd, exp_rd);
  endtask

  // One complete request on the LATENCY=2 build, starting in an IDLE cycle.
  task automatic access(input logic rd_req, input logic wr_req,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] load_val;
    mr = rd_req; mw = wr_req; addr = a; wdata = d;
    step();
    if ((a % 32'd4) != 32'd0) begin
      mr = 1'b0; mw = 1'b0;
      check({tag, ".err"},  32'(mis), 32'd1);
      check({tag, ".busy"}, 32'(bsy), 32'd0);
      check({tag, ".rdy"},  32'(rdy), 32'd0);
      check({tag, ".rd"},   rd, exp_rd);
      step();
      check_idle({tag, ".after"});
      return;
    end
    load_val = exp_rd;
    if (wr_req) ref_mem[word_of(a)] = d;
    else        load_val = ref_mem[word_of(a)];
    for (int c = 1; c <= LAT + 1; c++) begin
      check($sformatf("%s.busy%0d", tag, c), 32'(bsy), 32'd1);
      check($sformatf("%s.rdy%0d", tag, c), 32'(rdy), 32'(c == LAT + 1));
      check($sformatf("%s.rd%0d", tag, c), rd, (c == LAT + 1) ? load_val : exp_rd);
      // Anything driven while busy must be ignored.
      mr = 1'($urandom); mw = 1'($urandom); addr = $urandom; wdata = $urandom;
      step();
    end
    mr = 1'b0; mw = 1'b0;
    exp_rd = load_val;
    check_idle({tag, ".after"});
  endtask

  initial begin
    logic [31:0] r;
    int          op;
    int          idx;
    logic [31:0] a;

    reset = 1'b1;
    mr = 1'b1; mw = 1'b0; addr = 32'h40; wdata = 32'h0;
    mr0 = 1'b0; mw0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    exp_rd = 32'd0;
    step();
    step();
    check_idle("reset_req");
    check("reset0.rd", rd0, 32'd0);
    check("reset0.busy", 32'(bsy0), 32'd0);
    mr = 1'b0;
    reset = 1'b0;
    step();
    check_idle("post_reset");

    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, $sformatf("init%0d", i));

    access(1'b0, 1'b1, 32'h40, 32'hA5A5_0001, "st40");
    access(1'b1, 1'b0, 32'h40, 32'h0, "ld40");
    step();
    step();
    check("ld40.hold", rd, 32'hA5A5_0001);

    access(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, "st_wrap");
    access(1'b1, 1'b0, 32'h0000_0004, 32'h0, "ld_wrap");
    check("wrap.value", rd, 32'h1234_5678);

    access(1'b1, 1'b0, 32'h0000_0042, 32'h0, "misalign");

    mr = 1'b1; addr = 32'h42;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mis_hold.err%0d", i), 32'(mis), 32'(i % 2 == 0));
      check($sformatf("mis_hold.busy%0d", i), 32'(bsy), 32'd0);
    end
    mr = 1'b0;
    step();
    check_idle("mis_hold.end");

    access(1'b1, 1'b1, 32'h08, 32'h0F0F_0F0F, "both");
    access(1'b1, 1'b0, 32'h08, 32'h0, "ld_both");
    check("both.value", rd, 32'h0F0F_0F0F);

    access(1'b0, 1'b1, 32'h10, 32'h1111_1111, "st10");
    access(1'b1, 1'b0, 32'h10, 32'h0, "ld10");
    mw = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    step();
    mw = 1'b0;
    check("rst_wait.busy_before", 32'(bsy), 32'd1);
    reset = 1'b1;
    step();
    exp_rd = 32'd0;
    check_idle("rst_wait.c1");
    step();
    reset = 1'b0;
    check_idle("rst_wait.c2");
    step();
    access(1'b1, 1'b0, 32'h10, 32'h0, "rst_wait.ld");
    check("rst_wait.value", rd, 32'h1111_1111);

    mw = 1'b1; addr = 32'h10; wdata = 32'h2222_2222;
    step();
    mw = 1'b0;
    step();
    step();
    check("rst_done.rdy_before", 32'(rdy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rd = 32'd0;
    check_idle("rst_done");
    access(1'b1, 1'b0, 32'h10, 32'h0, "rst_done.ld");
    check("rst_done.value", rd, 32'h1111_1111);

    for (int n = 0; n < 40; n++) begin
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 15));
      r   = $urandom;
      a   = (r & 32'hFFFF_FC00) | 32'(idx * 4);
      if (op == 3) a = a | 32'($urandom_range(1, 3));
      case (op)
        0:       access(1'b1, 1'b0, a, $urandom, $sformatf("rnd%0d.ld", n));
        1:       access(1'b0, 1'b1, a, $urandom, $sformatf("rnd%0d.st", n));
        2:       access(1'b1, 1'b1, a, $urandom, $sformatf("rnd%0d.both", n));
        default: access(1'($urandom), 1'($urandom_range(0, 1) | 1), a, $urandom,
                        $sformatf("rnd%0d.mis", n));
      endcase
    end

    mw0 = 1'b1; addr0 = 32'h08; wdata0 = 32'hCAFE_0008;
    step();
    mw0 = 1'b0;
    check("l0_st.busy", 32'(bsy0), 32'd1);
    check("l0_st.rdy", 32'(rdy0), 32'd1);
    check("l0_st.rd", rd0, 32'd0);
    step();
    check("l0_st.busy_after", 32'(bsy0), 32'd0);
    check("l0_st.rdy_after", 32'(rdy0), 32'd0);
    mr0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("l0_hold.busy%0d", i), 32'(bsy0), 32'(i % 2 == 0));
      check($sformatf("l0_hold.rdy%0d", i), 32'(rdy0), 32'(i % 2 == 0));
      check($sformatf("l0_hold.rd%0d", i), rd0, 32'hCAFE_0008);
    end
    mr0 = 1'b0;
    step();
    check("l0_end.busy", 32'(bsy0), 32'd0);
    check("l0_end.rdy", 32'(rdy0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Word-addressed data memory stage directly downstream of the ALU. Consumes the ALU result as a byte address, plus store data from the register file. Performs one load or store per request with a programmable access latency, and tells the pipeline when the access is done through a busy/ready handshake. A misaligned request returns an error pulse and does not touch memory.

## Interface

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words. Must be a power of two; AW = log2(DEPTH_WORDS).
- LATENCY, 2: wait cycles between accept and completion. Range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  load request (level).
- mem_write  input  1  store request (level).
- ALU_result  input  32  byte address from the ALU.
- write_data  input  32  store data.
- read_data  output  32  load result.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  access in progress; pipeline must stall.
- misalign_err  output  1  one-cycle pulse on a rejected misaligned request.

## Operation

- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If (mem_read | mem_write) and ALU_result[1:0] == 0: latch index = ALU_result[AW+1:2], write_data, and op. Go to WAIT, or to DONE if LATENCY == 0.
  - If mem_write is asserted, op = store, even when mem_read is also asserted. Otherwise op = load.
  - If the request is misaligned: pulse misalign_err next cycle, stay in IDLE, no memory access.
- WAIT: 4-bit counter loaded with LATENCY-1 on entry and decremented each cycle. Go to DONE when it reaches 0.
- DONE:
  - Store writes the latched data to mem[index]. Load writes mem[index] to read_data.
  - mem_ready = 1, then return to IDLE.
- Address bits above AW+1 are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS*4.
- Inputs are sampled only in IDLE. Changes to address, data or requests during WAIT/DONE have no effect.
- read_data holds its value until the next load completes. Stores and misaligned requests leave it unchanged.
- busy = 1 in WAIT and DONE, 0 in IDLE.
- Memory contents are not cleared by reset.

## Timing

- Reset values: read_data = 0, mem_ready = 0, busy = 0, misalign_err = 0. FSM goes to IDLE, counter = 0.
- Request accepted at edge k (IDLE, aligned):
  - busy = 1 from k+1 through k+1+LATENCY.
  - mem_ready = 1 and read_data valid in cycle k+1+LATENCY only.
  - Store is visible to a load accepted at k+2+LATENCY or later.
- LATENCY = 0: a single DONE cycle, so busy and mem_ready are both high in cycle k+1.
- Back-to-back requests:
  - A request still asserted during the mem_ready cycle is not accepted until the IDLE cycle that follows.
  - The requester must drop its request on seeing mem_ready, or a second access starts.
  - Minimum spacing between accepts is LATENCY+2 cycles.
- Misaligned request sampled at edge k: misalign_err = 1 in cycle k+1 only, busy stays 0. A request held high re-pulses misalign_err every other cycle (IDLE, pulse, IDLE...).
- Reset mid-operation, while in WAIT or DONE:
  - FSM returns to IDLE on that edge and no store commits.
  - read_data is cleared to 0 and mem_ready is not asserted.
  - Reset overrides a simultaneous request.

## Test plan

- **Reset:** assert reset 2 cycles mid-WAIT of a store of 0xDEADBEEF to 0x10 -> all outputs 0 next cycle. A later load of 0x10 must not return 0xDEADBEEF; pre-load 0x10 with 0x11111111 and expect 0x11111111.
- **Store then load (LATENCY=2):** store 0xA5A5_0001 to 0x40 -> busy cycles k+1..k+3, mem_ready at k+3. Load 0x40 -> read_data = 0xA5A5_0001 with mem_ready, held after.
- **Wrap-around (DEPTH_WORDS=256):** store 0x12345678 to 0x0000_0404 -> a load from 0x0000_0004 returns 0x12345678.
- **Misaligned:** mem_read with ALU_result = 0x0000_0042 -> misalign_err one-cycle pulse, busy 0, mem_ready 0, read_data unchanged.
- **Simultaneous read and write:** both asserted with address 0x08 and data 0x0F0F0F0F -> treated as a store. read_data is unchanged, and a later load of 0x08 returns 0x0F0F0F0F.
- **LATENCY=0 build:** load 0x08 -> busy and mem_ready together in cycle k+1. Holding mem_read continuously gives accepts every 2 cycles.
